// File: rtl/expr_sequencer.sv
// Micro-programmed sequencer for the nibble-operand ALU datapath: fetches words from ROM and
// runs a 3-step configurable micro-program per word. Define OVERLAP_FETCH_EN to fetch the next word during EX2.
module expr_sequencer #(
    parameter int ADDR_W = 11,
    parameter int STEPS  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [4:0]        cfg_step0,
    input  logic [4:0]        cfg_step1,
    input  logic [4:0]        cfg_step2,
    input  logic              rom_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              reset_ir,
    output logic              load_reg,
    output logic              sel_mult0,
    output logic [1:0]        sel_mult1,
    output logic [1:0]        op,
    output logic              load_w,
    output logic              busy,
    output logic              result_valid,
    output logic              done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] words_done
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    if (STEPS != 3) begin : g_steps_check
        $error("expr_sequencer: STEPS must be 3");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_EX0, S_EX1, S_EX2, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] words_done_reg;
    logic [ADDR_W-1:0] rem_reg;
    logic              result_valid_reg;
    logic              cfg_err_reg;
    logic [4:0]        cfg_reg [STEPS];
    logic [4:0]        cfg_in  [STEPS];
    logic [STEPS-1:0]  cfg_bad;
    logic [4:0]        step_cfg;
    logic              ex_active;
    logic              start_req;
    logic              accept;
    logic              reject;
    logic              word_end;

    assign cfg_in[0] = cfg_step0;
    assign cfg_in[1] = cfg_step1;
    assign cfg_in[2] = cfg_step2;

    // sel_y encoding 2'b11 has no operand behind it, so such a program is refused
    genvar gi;
    for (gi = 0; gi < STEPS; gi++) begin : g_cfg_check
        assign cfg_bad[gi] = (cfg_in[gi][3:2] == 2'b11);
    end

    assign start_req = (state_reg == S_IDLE) && start && !abort;
    assign accept    = start_req && !(|cfg_bad);
    assign reject    = start_req && (|cfg_bad);
    assign word_end  = (state_reg == S_EX2) && !abort;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        reset_ir   = 1'b0;
        load_reg   = 1'b0;
        sel_mult0  = 1'b0;
        sel_mult1  = 2'b00;
        op         = 2'b00;
        load_w     = 1'b0;
        done       = 1'b0;
        ex_active  = 1'b0;
        step_cfg   = cfg_reg[0];
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CLEAR;
                    pc_next    = base_addr;
                end
            end
            S_CLEAR: begin
                reset_ir   = 1'b1;
                state_next = (rem_reg == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (rom_valid) begin
                    load_reg   = 1'b1;
                    pc_next    = pc_reg + ONE;
                    state_next = S_EX0;
                end
            end
            S_EX0: begin
                ex_active  = 1'b1;
                step_cfg   = cfg_reg[0];
                state_next = S_EX1;
            end
            S_EX1: begin
                ex_active  = 1'b1;
                step_cfg   = cfg_reg[1];
                state_next = S_EX2;
            end
            S_EX2: begin
                ex_active  = 1'b1;
                step_cfg   = cfg_reg[2];
                state_next = (rem_reg > ONE) ? S_FETCH : S_DONE;
`ifdef OVERLAP_FETCH_EN
                // next word is latched on the same edge W takes this word's last result
                if (rem_reg > ONE && rom_valid) begin
                    load_reg   = 1'b1;
                    pc_next    = pc_reg + ONE;
                    state_next = S_EX0;
                end
`endif
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (ex_active) begin
            sel_mult0 = step_cfg[4];
            sel_mult1 = step_cfg[3:2];
            op        = step_cfg[1:0];
            load_w    = 1'b1;
        end
        if (abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            pc_next    = pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            pc_reg           <= '0;
            words_done_reg   <= '0;
            rem_reg          <= '0;
            result_valid_reg <= 1'b0;
            cfg_err_reg      <= 1'b0;
            for (int i = 0; i < STEPS; i++) cfg_reg[i] <= '0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            result_valid_reg <= word_end;
            cfg_err_reg      <= reject;
            if (accept) begin
                words_done_reg <= '0;
                rem_reg        <= word_count;
                for (int i = 0; i < STEPS; i++) cfg_reg[i] <= cfg_in[i];
            end
            if (word_end) begin
                words_done_reg <= words_done_reg + ONE;
                rem_reg        <= rem_reg - ONE;
            end
        end
    end

    assign pc_out       = pc_reg;
    assign words_done   = words_done_reg;
    assign result_valid = result_valid_reg;
    assign cfg_err      = cfg_err_reg;
    assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_expr_sequencer.sv
// Directed bench for expr_sequencer: models ROM plus the a/b/c/d, mux, ALU and W datapath around it.
module tb_expr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [10:0] base_addr;
    logic [10:0] word_count;
    logic [4:0]  cfg_step0, cfg_step1, cfg_step2;
    logic        rom_valid;
    logic [10:0] pc_out;
    logic        reset_ir, load_reg, sel_mult0, load_w;
    logic [1:0]  sel_mult1, op;
    logic        busy, result_valid, done, cfg_err;
    logic [10:0] words_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    expr_sequencer #(.ADDR_W(11), .STEPS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .cfg_step0(cfg_step0), .cfg_step1(cfg_step1), .cfg_step2(cfg_step2),
        .rom_valid(rom_valid), .pc_out(pc_out), .reset_ir(reset_ir),
        .load_reg(load_reg), .sel_mult0(sel_mult0), .sel_mult1(sel_mult1),
        .op(op), .load_w(load_w), .busy(busy), .result_valid(result_valid),
        .done(done), .cfg_err(cfg_err), .words_done(words_done)
    );

    // ROM and datapath model
    logic [15:0] rom [2048];
    logic [15:0] rom_data;
    logic [3:0]  a, b, c, d;
    logic [7:0]  w, x, y, alu;

    assign rom_data = rom[pc_out];

    always_comb begin
        x = sel_mult0 ? {4'b0, a} : w;
        case (sel_mult1)
            2'd0:    y = {4'b0, b};
            2'd1:    y = {4'b0, c};
            2'd2:    y = {4'b0, d};
            default: y = 8'd0;
        endcase
        case (op)
            2'd0:    alu = x + y;
            2'd1:    alu = x - y;
            2'd2:    alu = x * y;
            default: alu = x;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            a <= 4'd0; b <= 4'd0; c <= 4'd0; d <= 4'd0; w <= 8'd0;
        end else begin
            if (reset_ir) begin
                a <= 4'd0; b <= 4'd0; c <= 4'd0; d <= 4'd0;
            end else if (load_reg) begin
                {d, c, b, a} <= rom_data;
            end
            if (load_w) w <= alu;
        end
    end

    // event logs
    int          rv_cnt = 0, ld_cnt = 0, rir_cnt = 0, done_cnt = 0;
    logic [7:0]  w_log  [256];
    logic [10:0] pc_log [256];

    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid) begin w_log[rv_cnt[7:0]] = w; rv_cnt++; end
            if (load_reg)     begin pc_log[ld_cnt[7:0]] = pc_out; ld_cnt++; end
            if (reset_ir)     rir_cnt++;
            if (done)         done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // start is sampled by the posedge this task returns just after (edge k)
    task automatic do_start(input logic [10:0] base, input logic [10:0] cnt);
        @(posedge clk); #1;
        base_addr = base; word_count = cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat = spec cycle index relative to k in which done is seen
    task automatic wait_done(input int first_e, output int lat);
        lat = -1;
        for (int e = first_e; e < 300; e++) begin
            @(negedge clk);
            if (done) begin lat = e + 1; break; end
        end
        @(posedge clk); #1;
    endtask

`ifdef OVERLAP_FETCH_EN
    localparam int LAT_MULTI   = 15;
    localparam int LAT_RESTART = 9;
    localparam int ABORT_E     = 6;
`else
    localparam int LAT_MULTI   = 18;
    localparam int LAT_RESTART = 10;
    localparam int ABORT_E     = 7;
`endif

    initial begin
        int lat, rv0, ld0, rir0, done0;

        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        rom[0]    = 16'h3251;
        rom[1]    = 16'h1123;
        rom[2]    = 16'h4A37;
        rom[5]    = 16'h3251;
        rom[2047] = 16'h2143;

        rst = 1'b1; start = 1'b0; abort = 1'b0; rom_valid = 1'b1;
        base_addr = 11'd0; word_count = 11'd0;
        cfg_step0 = 5'b1_10_00; cfg_step1 = 5'b0_00_10; cfg_step2 = 5'b0_01_01;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_pc", pc_out, 0);
        chk("reset_words_done", words_done, 0);
        chk("reset_ctrl", {reset_ir, load_reg, sel_mult0, sel_mult1, op, load_w}, 0);
        chk("reset_pulses", {result_valid, done, cfg_err}, 0);

        // single word: (a+d)*b-c with a=1 b=5 c=2 d=3
        rv0 = rv_cnt;
        do_start(11'd0, 11'd1);
        wait_done(0, lat);
        $display("run single: lat=%0d words_done=%0d pc=%0d", lat, words_done, pc_out);
        chk("single_lat", lat, 6);
        chk("single_rv_count", rv_cnt - rv0, 1);
        chk("single_w", w_log[rv0[7:0]], 18);
        chk("single_words_done", words_done, 1);
        chk("single_pc", pc_out, 1);
        chk("single_idle", busy, 0);

        // four words from the top of the address space, pc wraps
        rv0 = rv_cnt; ld0 = ld_cnt;
        do_start(11'd2047, 11'd4);
        wait_done(0, lat);
        $display("run multi: lat=%0d words_done=%0d pc=%0d", lat, words_done, pc_out);
        chk("multi_lat", lat, LAT_MULTI);
        chk("multi_rv_count", rv_cnt - rv0, 4);
        chk("multi_pc0", pc_log[ld0[7:0]], 2047);
        chk("multi_pc1", pc_log[8'(ld0 + 1)], 0);
        chk("multi_pc2", pc_log[8'(ld0 + 2)], 1);
        chk("multi_pc3", pc_log[8'(ld0 + 3)], 2);
        chk("multi_pc_end", pc_out, 3);
        chk("multi_w0", w_log[rv0[7:0]], 19);
        chk("multi_w1", w_log[8'(rv0 + 1)], 18);
        chk("multi_w2", w_log[8'(rv0 + 2)], 7);
        chk("multi_w3", w_log[8'(rv0 + 3)], 23);
        chk("multi_words_done", words_done, 4);

        // ROM stall: three FETCH cycles with rom_valid low
        rv0 = rv_cnt;
        rom_valid = 1'b0;
        do_start(11'd5, 11'd1);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_load_reg", load_reg, 0);
            chk("stall_pc", pc_out, 5);
        end
        @(posedge clk); #1;
        rom_valid = 1'b1;
        wait_done(4, lat);
        $display("run stall: lat=%0d words_done=%0d pc=%0d", lat, words_done, pc_out);
        chk("stall_lat", lat, 9);
        chk("stall_w", w_log[rv0[7:0]], 18);
        chk("stall_pc_end", pc_out, 6);

        // zero-count run
        rv0 = rv_cnt; ld0 = ld_cnt; rir0 = rir_cnt;
        do_start(11'd7, 11'd0);
        wait_done(0, lat);
        $display("run zero: lat=%0d words_done=%0d pc=%0d", lat, words_done, pc_out);
        chk("zero_lat", lat, 2);
        chk("zero_reset_ir", rir_cnt - rir0, 1);
        chk("zero_load_reg", ld_cnt - ld0, 0);
        chk("zero_rv", rv_cnt - rv0, 0);
        chk("zero_words_done", words_done, 0);

        // rejected configuration
        cfg_step1 = 5'b0_11_00;
        do_start(11'd0, 11'd2);
        @(negedge clk);
        $display("run reject: cfg_err=%0d busy=%0d", cfg_err, busy);
        chk("reject_cfg_err", cfg_err, 1);
        chk("reject_busy", busy, 0);
        @(negedge clk);
        chk("reject_cfg_err_pulse", cfg_err, 0);
        chk("reject_busy_after", busy, 0);
        cfg_step1 = 5'b0_00_10;

        // abort in EX1 of word 2 of 4, then restart
        rv0 = rv_cnt; done0 = done_cnt;
        do_start(11'd10, 11'd4);
        for (int e = 0; e <= ABORT_E; e++) @(negedge clk);
        chk("abort_in_ex", load_w, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        $display("run abort: busy=%0d words_done=%0d pc=%0d", busy, words_done, pc_out);
        chk("abort_busy", busy, 0);
        chk("abort_ctrl", {load_w, sel_mult0, sel_mult1, op, load_reg}, 0);
        chk("abort_words_done", words_done, 1);
        chk("abort_pc", pc_out, 12);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - done0, 0);
        chk("abort_rv", rv_cnt - rv0, 1);

        do_start(11'd0, 11'd2);
        wait_done(0, lat);
        $display("run restart: lat=%0d words_done=%0d pc=%0d", lat, words_done, pc_out);
        chk("restart_lat", lat, LAT_RESTART);
        chk("restart_words_done", words_done, 2);
        chk("restart_pc", pc_out, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
